// File: rtl/uart_apb_seq.sv
// APB master that configures a UART, then polls its status to move TX bytes into it and drain RX bytes out.
// Build option: define UART_SEQ_RX_DRAIN_EN to enable the RX drain path (RXR state, 0x0C reads, rx_valid/rx_dout).
module uart_apb_seq (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        cfg_start,
  input  logic [6:0]  cfg_con,
  input  logic [2:0]  cfg_se,
  input  logic [7:0]  cfg_brg,
  input  logic [4:0]  cfg_ie,
  output logic        cfg_done,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_dout,
  input  logic        rx_ready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SE_OFF, ST_BRG, ST_CON, ST_IE, ST_SE_ON, ST_POLL, ST_TXW, ST_RXR
  } state_t;

  // Every non-IDLE state is one transfer: idle gap, then SETUP, then ACCESS.
  typedef enum logic [1:0] {PH_GAP = 2'd0, PH_SETUP = 2'd1, PH_ACCESS = 2'd2} phase_t;

  state_t      state_r, state_nx_s;
  phase_t      phase_r, phase_nx_s;
  logic        pend_r, pend_nx_s, pend_s;
  logic [6:0]  con_r;
  logic [2:0]  se_r;
  logic [7:0]  brg_r;
  logic [4:0]  ie_r;
  logic [7:0]  tx_byte_r;
  logic        poll_done_s, rx_take_s, tx_take_s;
  logic [31:0] addr_s, wdata_s;
  logic        wr_s;
  logic        psel_r, penable_r, pwrite_r, cfg_done_r;
  logic [31:0] paddr_r, pwdata_r;
  logic        unused_s;

  assign pend_s      = pend_r | cfg_start;
  assign poll_done_s = (state_r == ST_POLL) && (phase_r == PH_ACCESS) && !pend_s;
`ifdef UART_SEQ_RX_DRAIN_EN
  logic       rx_valid_r;
  logic [7:0] rx_dout_r;
  assign rx_take_s = poll_done_s & prdata[6] & ~rx_valid_r;
  assign rx_valid  = rx_valid_r;
  assign rx_dout   = rx_dout_r;
  assign unused_s  = ^prdata[31:8];
`else
  assign rx_take_s = 1'b0;
  assign rx_valid  = 1'b0;
  assign rx_dout   = 8'd0;
  assign unused_s  = ^{prdata, rx_ready};
`endif
  // RX wins over TX; the byte is accepted in the POLL ACCESS cycle that decides TXW.
  assign tx_take_s = poll_done_s & ~rx_take_s & tx_valid & prdata[5];
  assign tx_ready  = tx_take_s;

  assign psel     = psel_r;
  assign penable  = penable_r;
  assign pwrite   = pwrite_r;
  assign paddr    = paddr_r;
  assign pwdata   = pwdata_r;
  assign cfg_done = cfg_done_r;

  // Next state / phase; a pending restart is honoured only once the current ACCESS completes.
  always_comb begin
    state_nx_s = state_r;
    phase_nx_s = phase_r;
    pend_nx_s  = pend_r | (cfg_start & (state_r != ST_IDLE));
    if (state_r == ST_IDLE) begin
      pend_nx_s  = 1'b0;
      phase_nx_s = PH_GAP;
      if (cfg_start) state_nx_s = ST_SE_OFF;
      else           state_nx_s = ST_IDLE;
    end else begin
      case (phase_r)
        PH_GAP:    phase_nx_s = PH_SETUP;
        PH_SETUP:  phase_nx_s = PH_ACCESS;
        PH_ACCESS: begin
          phase_nx_s = PH_GAP;
          if (pend_s) begin
            state_nx_s = ST_SE_OFF;
            pend_nx_s  = 1'b0;
          end else begin
            case (state_r)
              ST_SE_OFF: state_nx_s = ST_BRG;
              ST_BRG:    state_nx_s = ST_CON;
              ST_CON:    state_nx_s = ST_IE;
              ST_IE:     state_nx_s = ST_SE_ON;
              ST_SE_ON:  state_nx_s = se_r[0] ? ST_POLL : ST_IDLE;
              ST_POLL: begin
                if (rx_take_s)      state_nx_s = ST_RXR;
                else if (tx_take_s) state_nx_s = ST_TXW;
                else                state_nx_s = ST_POLL;
              end
              ST_TXW:    state_nx_s = ST_POLL;
              ST_RXR:    state_nx_s = ST_POLL;
              default:   state_nx_s = ST_IDLE;
            endcase
          end
        end
        default:   phase_nx_s = PH_GAP;
      endcase
    end
  end

  // Address/data/direction of the transfer owned by the upcoming state.
  always_comb begin
    addr_s  = 32'd0;
    wdata_s = 32'd0;
    wr_s    = 1'b1;
    case (state_nx_s)
      ST_SE_OFF: begin addr_s = 32'h04; wdata_s = {29'd0, se_r & 3'b110}; end
      ST_BRG:    begin addr_s = 32'h08; wdata_s = {24'd0, brg_r}; end
      ST_CON:    begin addr_s = 32'h00; wdata_s = {25'd0, con_r}; end
      ST_IE:     begin addr_s = 32'h10; wdata_s = {27'd0, ie_r}; end
      ST_SE_ON:  begin addr_s = 32'h04; wdata_s = {29'd0, se_r}; end
      ST_POLL:   begin addr_s = 32'h04; wr_s = 1'b0; end
      ST_TXW:    begin addr_s = 32'h0C; wdata_s = {24'd0, tx_byte_r}; end
      ST_RXR:    begin addr_s = 32'h0C; wr_s = 1'b0; end
      default:   begin addr_s = 32'd0; wr_s = 1'b0; end
    endcase
  end

  // Sequencer state, config capture and accepted TX byte.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_r   <= ST_IDLE;
      phase_r   <= PH_GAP;
      pend_r    <= 1'b0;
      con_r     <= 7'd0;
      se_r      <= 3'd0;
      brg_r     <= 8'd0;
      ie_r      <= 5'd0;
      tx_byte_r <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      phase_r <= phase_nx_s;
      pend_r  <= pend_nx_s;
      if (cfg_start) begin
        con_r <= cfg_con;
        se_r  <= cfg_se;
        brg_r <= cfg_brg;
        ie_r  <= cfg_ie;
      end
      if (tx_take_s) tx_byte_r <= tx_data;
    end
  end

  // Registered APB outputs: loaded at SETUP, held through ACCESS, zero on idle cycles.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      psel_r     <= 1'b0;
      penable_r  <= 1'b0;
      pwrite_r   <= 1'b0;
      paddr_r    <= 32'd0;
      pwdata_r   <= 32'd0;
      cfg_done_r <= 1'b0;
    end else begin
      cfg_done_r <= (state_nx_s == ST_POLL) || (state_nx_s == ST_TXW) || (state_nx_s == ST_RXR);
      if (phase_nx_s == PH_SETUP) begin
        psel_r    <= 1'b1;
        penable_r <= 1'b0;
        pwrite_r  <= wr_s;
        paddr_r   <= addr_s;
        pwdata_r  <= wdata_s;
      end else if (phase_nx_s == PH_ACCESS) begin
        psel_r    <= 1'b1;
        penable_r <= 1'b1;
      end else begin
        psel_r    <= 1'b0;
        penable_r <= 1'b0;
        pwrite_r  <= 1'b0;
        paddr_r   <= 32'd0;
        pwdata_r  <= 32'd0;
      end
    end
  end

`ifdef UART_SEQ_RX_DRAIN_EN
  // RX holding register: filled at the end of the 0x0C read, emptied by the consumer.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rx_valid_r <= 1'b0;
      rx_dout_r  <= 8'd0;
    end else if ((state_r == ST_RXR) && (phase_r == PH_ACCESS)) begin
      rx_valid_r <= 1'b1;
      rx_dout_r  <= prdata[7:0];
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_apb_seq.sv
// Scoreboard bench for uart_apb_seq: directed stimulus pushes expected APB transfers and TX/RX bytes; a monitor pops and compares.
module tb_uart_apb_seq;
  logic        pclk = 1'b0, prst_n = 1'b0, cfg_start = 1'b0;
  logic [6:0]  cfg_con = 7'd0;
  logic [2:0]  cfg_se = 3'd0;
  logic [7:0]  cfg_brg = 8'd0;
  logic [4:0]  cfg_ie = 5'd0;
  logic        tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        cfg_done, tx_ready, rx_valid, psel, penable, pwrite;
  logic [7:0]  rx_dout;
  logic [31:0] paddr, pwdata, prdata;
  logic [31:0] status_v = 32'd0;
  logic [7:0]  rxbyte_v = 8'd0;

  int n_vec = 0, n_err = 0, polls = 0, txr_cnt = 0, cyc = 0, last_acc = 0, p0 = 0, t0 = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        done;
    logic        gap;
  } apb_t;
  apb_t       apbq[$];
  apb_t       e;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  logic        p1_sel = 1'b0, p1_pen = 1'b0, p1_wr = 1'b0, p2_sel = 1'b0, p2_pen = 1'b0, rxv_q = 1'b0;
  logic [31:0] p1_addr = 32'd0, p1_data = 32'd0, p2_addr = 32'd0, p2_data = 32'd0;

  uart_apb_seq dut (
    .pclk(pclk), .prst_n(prst_n), .cfg_start(cfg_start), .cfg_con(cfg_con), .cfg_se(cfg_se),
    .cfg_brg(cfg_brg), .cfg_ie(cfg_ie), .cfg_done(cfg_done), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_dout(rx_dout), .rx_ready(rx_ready), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // UART register model: status at 0x04, RX data at 0x0C.
  assign prdata = (psel && !pwrite && paddr == 32'h04) ? status_v :
                  (psel && !pwrite && paddr == 32'h0C) ? {24'd0, rxbyte_v} : 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_apb(input logic [31:0] a, input logic [31:0] d, input logic w, input logic dn, input logic g);
    apbq.push_back('{a, d, w, dn, g});
  endtask

  task automatic start_cfg(input logic [2:0] se, input logic [7:0] brg, input logic [6:0] con, input logic [4:0] ie);
    @(posedge pclk); #1;
    cfg_se = se; cfg_brg = brg; cfg_con = con; cfg_ie = ie; cfg_start = 1'b1;
    @(posedge pclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && apbq.size() != 0; i++) @(negedge pclk);
    chk("apb_queue_drained", apbq.size(), 32'd0);
  endtask

  task automatic tx_wait(input int maxc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge pclk);
      if (tx_ready) begin got = 1'b1; break; end
    end
    chk("tx_ready_seen", got, 1'b1);
    @(posedge pclk); #1;
    tx_valid = 1'b0;
  endtask

  // Monitor: bus protocol, APB scoreboard, TX acceptance and RX delivery.
  initial begin
    forever begin
      @(negedge pclk);
      if (!prst_n) begin
        p1_sel = 1'b0; p1_pen = 1'b0; p1_wr = 1'b0; p1_addr = 32'd0; p1_data = 32'd0;
        p2_sel = 1'b0; p2_pen = 1'b0; p2_addr = 32'd0; p2_data = 32'd0; rxv_q = 1'b0;
      end else begin
        if (psel && penable) begin
          chk("setup_phase", {30'd0, p1_sel, p1_pen}, 32'd2);
          chk("setup_addr", p1_addr, paddr);
          chk("setup_wdata", p1_data, pwdata);
          chk("setup_wr", p1_wr, pwrite);
          chk("idle_gap", {30'd0, p2_sel, p2_pen} | p2_addr | p2_data, 32'd0);
          if (paddr == 32'h04 && !pwrite) begin
            polls++;
          end else if (apbq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_apb: got addr %h wr %b data %h, expected no transfer", paddr, pwrite, pwdata);
          end else begin
            e = apbq.pop_front();
            chk("apb_addr", paddr, e.addr);
            chk("apb_wr", pwrite, e.wr);
            if (e.wr) chk("apb_wdata", pwdata, e.data);
            chk("apb_cfg_done", cfg_done, e.done);
            if (e.gap) chk("apb_spacing", cyc - last_acc, 32'd3);
          end
          last_acc = cyc;
        end else if (!psel) begin
          chk("idle_bus", {31'd0, penable} | paddr | pwdata, 32'd0);
        end
        if (tx_ready) begin
          txr_cnt++;
          chk("tx_ready_with_valid", tx_valid, 1'b1);
          if (txq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_tx_ready: got data %h, expected no acceptance", tx_data);
          end else chk("tx_byte", tx_data, txq.pop_front());
        end
        if (rx_valid && !rxv_q) begin
          if (rxq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rx_valid: got %h, expected none", rx_dout);
          end else chk("rx_dout", rx_dout, rxq.pop_front());
        end
        rxv_q = rx_valid;
        p2_sel = p1_sel; p2_pen = p1_pen; p2_addr = p1_addr; p2_data = p1_data;
        p1_sel = psel; p1_pen = penable; p1_wr = pwrite; p1_addr = paddr; p1_data = pwdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    repeat (2) @(negedge pclk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx", {23'd0, rx_valid, rx_dout}, 32'd0);
    @(posedge pclk); #1;
    prst_n = 1'b1;

    // Configuration sequence, enable bit set.
    exp_apb(32'h04, 32'h00, 1'b1, 1'b0, 1'b0);
    exp_apb(32'h08, 32'h1A, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h00, 32'h08, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h10, 32'h01, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h04, 32'h01, 1'b1, 1'b0, 1'b1);
    start_cfg(3'b001, 8'h1A, 7'h08, 5'h01);
    wait_drain(40);
    @(negedge pclk);
    chk("cfg_done_run", cfg_done, 1'b1);

    // TX with room in the FIFO.
    @(posedge pclk); #1;
    status_v = 32'h20;
    txq.push_back(8'h55);
    exp_apb(32'h0C, 32'h55, 1'b1, 1'b1, 1'b0);
    tx_data = 8'h55; tx_valid = 1'b1;
    tx_wait(30);
    wait_drain(20);

    // TX FIFO full: polling repeats, nothing accepted until room appears.
    status_v = 32'h00;
    tx_data = 8'hA3; tx_valid = 1'b1;
    p0 = polls; t0 = txr_cnt;
    repeat (20) @(posedge pclk);
    chk("no_ready_while_full", txr_cnt - t0, 32'd0);
    chk("polls_repeat", {31'd0, (polls - p0) >= 5}, 32'd1);
    txq.push_back(8'hA3);
    exp_apb(32'h0C, 32'hA3, 1'b1, 1'b1, 1'b0);
    #1 status_v = 32'h20;
    tx_wait(20);
    wait_drain(20);

    // Offer withdrawn before any capture: nothing written.
    status_v = 32'h00;
    tx_data = 8'hEE; tx_valid = 1'b1;
    t0 = txr_cnt;
    repeat (6) @(posedge pclk);
    #1 tx_valid = 1'b0; status_v = 32'h20;
    repeat (15) @(posedge pclk);
    chk("no_capture_after_drop", txr_cnt - t0, 32'd0);

`ifdef UART_SEQ_RX_DRAIN_EN
    // RX has priority; byte held until consumed, then TX proceeds.
    #1;
    rxbyte_v = 8'hC3;
    rxq.push_back(8'hC3);
    txq.push_back(8'h77);
    exp_apb(32'h0C, 32'h00, 1'b0, 1'b1, 1'b0);
    exp_apb(32'h0C, 32'h77, 1'b1, 1'b1, 1'b1);
    tx_data = 8'h77; tx_valid = 1'b1; status_v = 32'h60;
    tx_wait(40);
    wait_drain(20);
    repeat (6) @(negedge pclk);
    chk("rx_valid_held", rx_valid, 1'b1);
    chk("rx_dout_held", rx_dout, 8'hC3);
    @(posedge pclk); #1;
    status_v = 32'h00; rx_ready = 1'b1;
    @(posedge pclk); #1;
    rx_ready = 1'b0;
    @(negedge pclk);
    chk("rx_valid_cleared", rx_valid, 1'b0);
`else
    // Without the drain path, RX status is ignored.
    #1 status_v = 32'h60; rx_ready = 1'b1;
    repeat (15) @(posedge pclk);
    @(negedge pclk);
    chk("rx_off_valid", rx_valid, 1'b0);
    chk("rx_off_dout", rx_dout, 8'h00);
    rx_ready = 1'b0;
`endif

    // Restart requested while the TX write is in flight.
    @(posedge pclk); #1;
    status_v = 32'h20;
    txq.push_back(8'h3C);
    exp_apb(32'h0C, 32'h3C, 1'b1, 1'b1, 1'b0);
    exp_apb(32'h04, 32'h06, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h08, 32'h22, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h00, 32'h11, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h10, 32'h1F, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h04, 32'h07, 1'b1, 1'b0, 1'b1);
    tx_data = 8'h3C; tx_valid = 1'b1;
    tx_wait(30);
    start_cfg(3'b111, 8'h22, 7'h11, 5'h1F);
    wait_drain(40);
    @(negedge pclk);
    chk("cfg_done_after_restart", cfg_done, 1'b1);

    // Reset asserted during an ACCESS cycle.
    #1 status_v = 32'h00;
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge pclk);
        if (psel && penable) begin found = 1'b1; break; end
      end
      chk("access_found", found, 1'b1);
    end
    #2 prst_n = 1'b0;
    #1;
    chk("async_rst_psel", psel, 1'b0);
    chk("async_rst_penable", penable, 1'b0);
    chk("async_rst_paddr", paddr, 32'd0);
    chk("async_rst_cfg_done", cfg_done, 1'b0);
    repeat (2) @(posedge pclk);
    #1 prst_n = 1'b1;

    // Enable bit clear: sequence ends in IDLE with no polling.
    exp_apb(32'h04, 32'h02, 1'b1, 1'b0, 1'b0);
    exp_apb(32'h08, 32'h00, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h00, 32'h7F, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h10, 32'h00, 1'b1, 1'b0, 1'b1);
    exp_apb(32'h04, 32'h02, 1'b1, 1'b0, 1'b1);
    start_cfg(3'b010, 8'h00, 7'h7F, 5'h00);
    wait_drain(40);
    p0 = polls;
    repeat (12) @(negedge pclk);
    chk("idle_cfg_done", cfg_done, 1'b0);
    chk("idle_no_polls", polls - p0, 32'd0);
    chk("idle_psel", psel, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
